data_mem_access: RTL and testbench

Memory-stage access controller that sits directly downstream of the EX/MEM pipeline register. It consumes that register's memRead, memWrite, aluResult (address) and rtData (store data) outputs, runs a req/ack handshake with the data memory, and returns load data toward MEM/WB. While an access is outstanding it drives stall_o, which holds EX/MEM and every earlier stage. It also flags misaligned and timed-out accesses.

---
 rtl/data_mem_access.sv | 133 +++++++++++++
 tb/tb_data_mem_access.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access.sv
// Memory-stage access controller: req/ack handshake with data memory,
// pipeline stall generation, misalignment and timeout detection.
module data_mem_access #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memRead_i,
    input  logic        memWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic access;
    logic aligned;

    assign access  = memRead_i | memWrite_i;
    assign aligned = (addr_i[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (access && !aligned) begin
                    err_d  = 1'b1;
                    code_d = 2'b01;
                end else if (access) begin
                    req_d   = 1'b1;
                    we_d    = memWrite_i;
                    addr_d  = {addr_i[31:2], 2'b00};
                    wdata_d = wdata_i;
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                    if (memRead_i && memWrite_i) begin
                        err_d  = 1'b1;
                        code_d = 2'b11;
                    end
                end
            end
            WAIT: begin
                // An ack in the final counted cycle beats the timeout.
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) rdata_d = mem_rdata_i;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    state_d = DONE;
                    if (!we_q) rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Gated by reset so the pipeline is released while reset is held.
    assign stall_o = rst_i &
                     ((state_q == WAIT) ||
                      ((state_q == IDLE) && access && aligned));

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: load, store, misalignment,
// timeout, back-to-back and mid-access reset scenarios.
module tb_data_mem_access;

    logic        clk;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_access #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .memRead_i   (memRead),
        .memWrite_i  (memWrite),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .stall_o     (stall),
        .rdata_o     (rdata),
        .err_o       (err),
        .err_code_o  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: drives one access starting at the current cycle,
    // acks in cycle lat (lat = 0 means never), and returns one cycle
    // after the first stall-free cycle with the inputs released.
    task automatic do_access(input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int lat, input logic [31:0] rdv,
                             output int stalls, output int reqs,
                             output bit stable);
        logic prev;
        prev     = mem_req;
        stalls   = 0;
        reqs     = 0;
        stable   = 1'b1;
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = wd;
        for (int c = 0; c < 40; c++) begin
            mem_ack   = (lat > 0) && (c == lat);
            mem_rdata = (c == lat) ? rdv : 32'h0;
            #1;
            if (mem_req && !prev) reqs++;
            prev = mem_req;
            if (mem_req && (mem_addr !== {a[31:2], 2'b00} ||
                            mem_wdata !== wd || mem_we !== wr))
                stable = 1'b0;
            if (!stall) break;
            stalls++;
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req got %0b want 0", mem_req);
        end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus got %h/%h/%0b want 0", mem_addr, mem_wdata, mem_we);
        end
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata got %h want 0", rdata);
        end
        n_checks++;
        if (err !== 1'b0 || err_code !== 2'b00) begin
            n_fail++; $display("FAIL reset_err got %0b/%b want 0/00", err, err_code);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall got %0b want 0", stall);
        end
        n_checks++;
    endtask

    task automatic test_load;
        int s, r;
        bit st;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'h1234_5678, s, r, st);
        if (s !== 2) begin
            n_fail++; $display("FAIL load_stalls got %0d want 2", s);
        end
        n_checks++;
        if (r !== 1) begin
            n_fail++; $display("FAIL load_reqs got %0d want 1", r);
        end
        n_checks++;
        if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL load_bus got %h/%0b want 10/0", mem_addr, mem_we);
        end
        n_checks++;
        if (rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL load_rdata got %h want 12345678", rdata);
        end
        n_checks++;
        if (mem_req !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL load_after got req %0b err %0b want 0/0", mem_req, err);
        end
        n_checks++;
    endtask

    task automatic test_store;
        int s, r;
        bit st;
        do_access(1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, 5, 32'h9999_9999, s, r, st);
        if (s !== 6) begin
            n_fail++; $display("FAIL store_stalls got %0d want 6", s);
        end
        n_checks++;
        if (!st) begin
            n_fail++; $display("FAIL store_stable got 0 want 1");
        end
        n_checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'h24) begin
            n_fail++;
            $display("FAIL store_bus got %0b/%h/%h want 1/cafef00d/24", mem_we, mem_wdata, mem_addr);
        end
        n_checks++;
        if (rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL store_rdata got %h want 12345678", rdata);
        end
        n_checks++;
        if (r !== 1 || err !== 1'b0) begin
            n_fail++; $display("FAIL store_reqs got %0d err %0b want 1/0", r, err);
        end
        n_checks++;
    endtask

    task automatic test_back_to_back;
        int s1, r1, s2, r2;
        bit st;
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hAAAA_0040, s1, r1, st);
        if (mem_addr !== 32'h40 || rdata !== 32'hAAAA_0040) begin
            n_fail++; $display("FAIL b2b_first got %h/%h want 40/aaaa0040", mem_addr, rdata);
        end
        n_checks++;
        do_access(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'hBBBB_0044, s2, r2, st);
        if (mem_addr !== 32'h44 || rdata !== 32'hBBBB_0044) begin
            n_fail++; $display("FAIL b2b_second got %h/%h want 44/bbbb0044", mem_addr, rdata);
        end
        n_checks++;
        if (s1 !== 2 || s2 !== 2) begin
            n_fail++; $display("FAIL b2b_stalls got %0d/%0d want 2/2", s1, s2);
        end
        n_checks++;
        if (r1 !== 1 || r2 !== 1) begin
            n_fail++; $display("FAIL b2b_reqs got %0d/%0d want 1/1", r1, r2);
        end
        n_checks++;
    endtask

    task automatic test_misaligned;
        int s, r;
        bit st;
        do_access(1'b1, 1'b0, 32'h13, 32'h0, 1, 32'h7777_7777, s, r, st);
        if (s !== 0 || r !== 0) begin
            n_fail++; $display("FAIL mis_stall_req got %0d/%0d want 0/0", s, r);
        end
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'b01) begin
            n_fail++; $display("FAIL mis_err got %0b/%b want 1/01", err, err_code);
        end
        n_checks++;
        if (rdata !== 32'hBBBB_0044) begin
            n_fail++; $display("FAIL mis_rdata got %h want bbbb0044", rdata);
        end
        n_checks++;
    endtask

    task automatic test_timeout;
        int s, r;
        bit st;
        do_access(1'b1, 1'b0, 32'h60, 32'h0, 0, 32'h0, s, r, st);
        if (s !== 17) begin
            n_fail++; $display("FAIL to_stalls got %0d want 17", s);
        end
        n_checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL to_rdata got %h want deadbeef", rdata);
        end
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'b10) begin
            n_fail++; $display("FAIL to_err got %0b/%b want 1/10", err, err_code);
        end
        n_checks++;
        if (mem_req !== 1'b0 || r !== 1) begin
            n_fail++; $display("FAIL to_req got %0b reqs %0d want 0/1", mem_req, r);
        end
        n_checks++;
    endtask

    task automatic test_conflict;
        int s, r;
        bit st;
        do_access(1'b1, 1'b1, 32'h80, 32'h0BAD_CAFE, 2, 32'h3333_3333, s, r, st);
        if (s !== 3) begin
            n_fail++; $display("FAIL rw_stalls got %0d want 3", s);
        end
        n_checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h0BAD_CAFE) begin
            n_fail++; $display("FAIL rw_bus got %0b/%h want 1/0badcafe", mem_we, mem_wdata);
        end
        n_checks++;
        if (err_code !== 2'b11) begin
            n_fail++; $display("FAIL rw_code got %b want 11", err_code);
        end
        n_checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rw_rdata got %h want deadbeef", rdata);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_wait;
        memRead = 1'b1;
        addr    = 32'h50;
        @(posedge clk);
        #1;
        if (mem_req !== 1'b1 || stall !== 1'b1) begin
            n_fail++; $display("FAIL mr_wait got req %0b stall %0b want 1/1", mem_req, stall);
        end
        n_checks++;
        rst = 1'b0;
        #1;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL mr_async got req %0b stall %0b want 0/0", mem_req, stall);
        end
        n_checks++;
        if (rdata !== 32'h0 || err !== 1'b0) begin
            n_fail++; $display("FAIL mr_clear got %h err %0b want 0/0", rdata, err);
        end
        n_checks++;
        memRead = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        #1;
        if (rdata !== 32'h0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL mr_late_ack got %h req %0b want 0/0", rdata, mem_req);
        end
        n_checks++;
        if (err !== 1'b0 || err_code !== 2'b00 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_late_err got %0b/%b stall %0b want 0/00/0", err, err_code, stall);
        end
        n_checks++;
    endtask

    initial begin
        rst       = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #12;
        test_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_load;
        test_store;
        test_back_to_back;
        test_misaligned;
        test_timeout;
        test_conflict;
        test_reset_mid_wait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
